// File: rtl/mult8_pkg.sv
// Shared definitions for the 8x8 multiplier control unit.
//   state_t     : FSM state encoding (step states LOAD_XY..LOAD_RES are
//                 numbered 1..8 so the LD strobe index is state-1)
//   ROM_*       : SELROM codes, which partial-product ROM operand to use
//   SOMA_*      : SELSOMA codes, which adder combination to use
//   CNT_W       : width of the settle/timeout counter
//   N_LD        : number of LD_* strobes
// Optional feature macro used by the control unit: UC_MULT_PRONTO_CHECK_EN.
package mult8_pkg;

  localparam int CNT_W   = 4;
  localparam int STATE_W = 4;
  localparam int N_LD    = 8;

  localparam logic [1:0] ROM_DE0 = 2'd0;
  localparam logic [1:0] ROM_A   = 2'd1;
  localparam logic [1:0] ROM_B   = 2'd2;
  localparam logic [1:0] ROM_DE1 = 2'd3;

  localparam logic [1:0] SOMA_NONE  = 2'd0;
  localparam logic [1:0] SOMA_AB    = 2'd1;
  localparam logic [1:0] SOMA_SHIFT = 2'd2;
  localparam logic [1:0] SOMA_RES   = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_LOAD_XY     = 4'd1,
    ST_LOAD_DE0    = 4'd2,
    ST_LOAD_A      = 4'd3,
    ST_LOAD_B      = 4'd4,
    ST_LOAD_DE1    = 4'd5,
    ST_LOAD_AB     = 4'd6,
    ST_SHIFT       = 4'd7,
    ST_LOAD_RES    = 4'd8,
    ST_WAIT_PRONTO = 4'd9,
    ST_DONE        = 4'd10,
    ST_ERR         = 4'd11
  } state_t;

  function automatic logic is_step(input state_t s);
    return (s >= ST_LOAD_XY) && (s <= ST_LOAD_RES);
  endfunction

  function automatic logic [1:0] selrom_of(input state_t s);
    logic [1:0] r;
    r = ROM_DE0;
    case (s)
      ST_LOAD_A:   r = ROM_A;
      ST_LOAD_B:   r = ROM_B;
      ST_LOAD_DE1: r = ROM_DE1;
      default:     r = ROM_DE0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] selsoma_of(input state_t s);
    logic [1:0] r;
    r = SOMA_NONE;
    case (s)
      ST_LOAD_AB:  r = SOMA_AB;
      ST_SHIFT:    r = SOMA_SHIFT;
      ST_LOAD_RES: r = SOMA_RES;
      default:     r = SOMA_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uc_multiplier8bits_if.sv
// Control bundle between the multiplier control unit and its surroundings.
//   START/PRONTO          : requests/status into the control unit
//   LD_* / SELROM/SELSOMA : datapath strobes and selects out of the unit
//   BUSY/DONE/ERRO        : status out of the unit
// Modports: slave = the control unit, master = the requester/datapath side.
interface uc_multiplier8bits_if;
  logic       START;
  logic       PRONTO;
  logic       LD_XY;
  logic       LD_DE0;
  logic       LD_A;
  logic       LD_B;
  logic       LD_DE1;
  logic       LD_AB;
  logic       LD_DE_ABshift;
  logic       LD_RES;
  logic [1:0] SELROM;
  logic [1:0] SELSOMA;
  logic       BUSY;
  logic       DONE;
  logic       ERRO;

  modport slave (
    input  START, PRONTO,
    output LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES,
    output SELROM, SELSOMA, BUSY, DONE, ERRO
  );

  modport master (
    output START, PRONTO,
    input  LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES,
    input  SELROM, SELSOMA, BUSY, DONE, ERRO
  );
endinterface

// File: rtl/uc_step_timer.sv
// Settle / timeout down-counter for the multiplier control unit.
//   clk      : clock
//   rst_n    : synchronous active-low reset (count -> 0)
//   clr      : force count to 0
//   load     : load load_val (clr has priority)
//   load_val : value loaded on load
//   zero     : count is 0 (last cycle of a step / timeout reached)
// The counter decrements every cycle and holds at 0, so it can never wrap.
module uc_step_timer
  import mult8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/uc_multiplier8bits.sv
// Control unit for the 8x8 multiplier datapath FD_multiplier8bits.
// One multiplication per START handshake: operand load, four partial-product
// ROM lookups, sum, shift-combine, result load, then DONE until START drops.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-low reset
//   bus   : uc_multiplier8bits_if.slave (START/PRONTO in; LD_*, SELROM,
//           SELSOMA, BUSY, DONE, ERRO out)
// Parameters:
//   SETTLE_CYCLES  : extra cycles each step holds its selects before its LD
//   PRONTO_TIMEOUT : cycles to wait for PRONTO before flagging ERRO
// Optional feature: define UC_MULT_PRONTO_CHECK_EN to wait for the datapath
// PRONTO flag after LOAD_RES (timeout -> ERR). Without it LOAD_RES goes
// straight to DONE, PRONTO is ignored and ERRO is constant 0.
// All outputs are registered decodes of the current state and timer flag,
// so every strobe appears one cycle after the state that produces it.
module uc_multiplier8bits
  import mult8_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 0,
  parameter int PRONTO_TIMEOUT = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  uc_multiplier8bits_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(PRONTO_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             step_zero;
  logic             timer_clr, timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [N_LD-1:0]  ld_d, ld_q;
  logic [1:0]       selrom_d, selrom_q, selsoma_d, selsoma_q;
  logic             busy_d, busy_q, done_d, done_q, erro_d, erro_q;
  logic             unused_pronto;

  assign unused_pronto = bus.PRONTO;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.START) state_d = ST_LOAD_XY;
      ST_LOAD_XY:  if (step_zero) state_d = ST_LOAD_DE0;
      ST_LOAD_DE0: if (step_zero) state_d = ST_LOAD_A;
      ST_LOAD_A:   if (step_zero) state_d = ST_LOAD_B;
      ST_LOAD_B:   if (step_zero) state_d = ST_LOAD_DE1;
      ST_LOAD_DE1: if (step_zero) state_d = ST_LOAD_AB;
      ST_LOAD_AB:  if (step_zero) state_d = ST_SHIFT;
      ST_SHIFT:    if (step_zero) state_d = ST_LOAD_RES;
      ST_LOAD_RES: begin
        if (step_zero) begin
`ifdef UC_MULT_PRONTO_CHECK_EN
          state_d = ST_WAIT_PRONTO;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_WAIT_PRONTO: begin
`ifdef UC_MULT_PRONTO_CHECK_EN
        // PRONTO beats the timeout when both land on the same edge
        if (bus.PRONTO) begin
          state_d = ST_DONE;
        end else if (step_zero) begin
          state_d = ST_ERR;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      // 4-phase handshake: leave only once the requester drops START
      ST_DONE, ST_ERR: if (!bus.START) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Timer restarts on every state change: step length for step states,
  // PRONTO window for the wait state, cleared otherwise.
  always_comb begin
    timer_clr  = 1'b0;
    timer_load = 1'b0;
    timer_val  = SETTLE_LOAD;
    if (state_d != state_q) begin
      if (is_step(state_d)) begin
        timer_load = 1'b1;
      end else if (state_d == ST_WAIT_PRONTO) begin
        timer_load = 1'b1;
        timer_val  = TIMEOUT_LOAD;
      end else begin
        timer_clr = 1'b1;
      end
    end
  end

  uc_step_timer u_step_timer (
    .clk      (CLK),
    .rst_n    (RESET),
    .clr      (timer_clr),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (step_zero)
  );

  always_comb begin
    selrom_d  = selrom_of(state_q);
    selsoma_d = selsoma_of(state_q);
    busy_d    = is_step(state_q) || (state_q == ST_WAIT_PRONTO);
    done_d    = (state_q == ST_DONE);
`ifdef UC_MULT_PRONTO_CHECK_EN
    erro_d    = (state_q == ST_ERR);
`else
    erro_d    = 1'b0;
`endif
  end

  // Strobe gi belongs to step state gi+1; it fires only in the step's last cycle.
  generate
    for (genvar gi = 0; gi < N_LD; gi++) begin : g_ld
      assign ld_d[gi] = step_zero && (state_q == STATE_W'(gi + 1));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      ld_q      <= '0;
      selrom_q  <= '0;
      selsoma_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      selrom_q  <= selrom_d;
      selsoma_q <= selsoma_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.LD_XY         = ld_q[0];
  assign bus.LD_DE0        = ld_q[1];
  assign bus.LD_A          = ld_q[2];
  assign bus.LD_B          = ld_q[3];
  assign bus.LD_DE1        = ld_q[4];
  assign bus.LD_AB         = ld_q[5];
  assign bus.LD_DE_ABshift = ld_q[6];
  assign bus.LD_RES        = ld_q[7];
  assign bus.SELROM        = selrom_q;
  assign bus.SELSOMA       = selsoma_q;
  assign bus.BUSY          = busy_q;
  assign bus.DONE          = done_q;
  assign bus.ERRO          = erro_q;

endmodule

// File: tb/tb_uc_multiplier8bits.sv
// Bench for uc_multiplier8bits: two instances (SETTLE_CYCLES 0 and 2) share
// START/PRONTO/RESET; outputs are compared every cycle with a cycle-indexed
// reference model. A small behavioural datapath driven by the default
// instance checks end-to-end products. Optional macro: UC_MULT_PRONTO_CHECK_EN.
`timescale 1ns/1ps
module tb_uc_multiplier8bits;

`ifdef UC_MULT_PRONTO_CHECK_EN
  localparam int EXTRA = 1;
  localparam logic PRONTO_IDLE = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam logic PRONTO_IDLE = 1'b0;
`endif
  localparam int TMO = 8;
  localparam int L0  = 8 * 1 + 1 + EXTRA;
  localparam int L2  = 8 * 3 + 1 + EXTRA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, pronto;
  int   n_checks = 0;
  int   n_pass   = 0;

  uc_multiplier8bits_if if0 ();
  uc_multiplier8bits_if if2 ();
  assign if0.START  = start;
  assign if0.PRONTO = pronto;
  assign if2.START  = start;
  assign if2.PRONTO = pronto;

  uc_multiplier8bits #(.SETTLE_CYCLES(0), .PRONTO_TIMEOUT(TMO)) dut0 (
    .CLK(clk), .RESET(rst_n), .bus(if0.slave));
  uc_multiplier8bits #(.SETTLE_CYCLES(2), .PRONTO_TIMEOUT(TMO)) dut2 (
    .CLK(clk), .RESET(rst_n), .bus(if2.slave));

  logic [14:0] got0, got2, exp0, exp2;
  assign got0 = {if0.LD_XY, if0.LD_DE0, if0.LD_A, if0.LD_B, if0.LD_DE1, if0.LD_AB,
                 if0.LD_DE_ABshift, if0.LD_RES, if0.SELROM, if0.SELSOMA,
                 if0.BUSY, if0.DONE, if0.ERRO};
  assign got2 = {if2.LD_XY, if2.LD_DE0, if2.LD_A, if2.LD_B, if2.LD_DE1, if2.LD_AB,
                 if2.LD_DE_ABshift, if2.LD_RES, if2.SELROM, if2.SELSOMA,
                 if2.BUSY, if2.DONE, if2.ERRO};

  // Expected outputs k cycles after the edge that sampled START in IDLE.
  // Step n (0..7) spans cycles n*(s+1)+1 .. (n+1)*(s+1); its LD is the last.
  // e = last edge at which DONE is still shown (first edge >= L with START low).
  function automatic logic [14:0] exp_vec(input int s, input int k, input int e);
    int per, nstep, l, st, ph;
    logic [7:0] ld;
    logic [1:0] rom, soma;
    logic busy, done;
    per = s + 1; nstep = 8 * per; l = nstep + 1 + EXTRA;
    ld = '0; rom = '0; soma = '0; busy = 1'b0; done = 1'b0;
    if (k >= 1 && k <= nstep) begin
      st = (k - 1) / per; ph = (k - 1) % per; busy = 1'b1;
      if (ph == s) ld = 8'h80 >> st;
      if (st >= 1 && st <= 4) rom = 2'(st - 1);
      if (st >= 5) soma = 2'(st - 4);
    end else if (EXTRA == 1 && k == nstep + 1) begin
      busy = 1'b1;
    end else if (k >= l && k <= e) begin
      done = 1'b1;
    end
    return {ld, rom, soma, busy, done, 1'b0};
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Behavioural stand-in for FD_multiplier8bits (nibble partial products).
  logic [7:0]  dp_xin, dp_yin, dp_x, dp_y, dp_de0, dp_a, dp_b, dp_de1, rom_out;
  logic [8:0]  dp_ab;
  logic [15:0] dp_sh, dp_res;
  always_comb begin
    rom_out = '0;
    case (if0.SELROM)
      2'd0: rom_out = {4'h0, dp_x[3:0]} * {4'h0, dp_y[3:0]};
      2'd1: rom_out = {4'h0, dp_x[7:4]} * {4'h0, dp_y[3:0]};
      2'd2: rom_out = {4'h0, dp_x[3:0]} * {4'h0, dp_y[7:4]};
      default: rom_out = {4'h0, dp_x[7:4]} * {4'h0, dp_y[7:4]};
    endcase
  end
  always @(posedge clk) begin
    if (if0.LD_XY) begin dp_x <= dp_xin; dp_y <= dp_yin; end
    if (if0.LD_DE0) dp_de0 <= rom_out;
    if (if0.LD_A)   dp_a   <= rom_out;
    if (if0.LD_B)   dp_b   <= rom_out;
    if (if0.LD_DE1) dp_de1 <= rom_out;
    if (if0.LD_AB)  dp_ab  <= (if0.SELSOMA == 2'd1) ? {1'b0, dp_a} + {1'b0, dp_b} : 9'h0;
    if (if0.LD_DE_ABshift)
      dp_sh <= (if0.SELSOMA == 2'd2) ? {dp_de1, dp_de0} + {3'b000, dp_ab, 4'h0} : 16'h0;
    if (if0.LD_RES) dp_res <= (if0.SELSOMA == 2'd3) ? dp_sh : 16'h0;
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_checks += 2;
      if (got0 !== 15'h0) $display("FAIL reset dut0 got=%h exp=%h", got0, 15'h0); else n_pass++;
      if (got2 !== 15'h0) $display("FAIL reset dut2 got=%h exp=%h", got2, 15'h0); else n_pass++;
    end
    rst_n = 1'b1;
    for (int k = 0; k <= 1; k++) begin
      @(posedge clk); #1;
      exp0 = exp_vec(0, k, 1000); exp2 = exp_vec(2, k, 1000);
      n_checks += 2;
      if (got0 !== exp0) $display("FAIL release dut0 k=%0d got=%h exp=%h", k, got0, exp0); else n_pass++;
      if (got2 !== exp2) $display("FAIL release dut2 k=%0d got=%h exp=%h", k, got2, exp2); else n_pass++;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks += 2;
    if (got0 !== 15'h0) $display("FAIL drain dut0 got=%h exp=%h", got0, 15'h0); else n_pass++;
    if (got2 !== 15'h0) $display("FAIL drain dut2 got=%h exp=%h", got2, 15'h0); else n_pass++;
    $display("txn reset: held 2 cycles, released with START high");
  endtask

  task automatic test_sequence(input int runs, input logic rnd_pronto);
    int d, e0, e2;
    for (int r = 0; r < runs; r++) begin
      d = $urandom_range(1, L2 + 6);
      e0 = maxi(d, L0); e2 = maxi(d, L2);
      start = 1'b1;
      for (int k = 0; k <= maxi(e0, e2) + 1; k++) begin
        @(posedge clk); #1;
        exp0 = exp_vec(0, k, e0); exp2 = exp_vec(2, k, e2);
        n_checks += 2;
        if (got0 !== exp0) $display("FAIL seq dut0 k=%0d got=%h exp=%h", k, got0, exp0); else n_pass++;
        if (got2 !== exp2) $display("FAIL seq dut2 k=%0d got=%h exp=%h", k, got2, exp2); else n_pass++;
        if (k + 1 == d) start = 1'b0;
        if (rnd_pronto) pronto = 1'($urandom);
      end
      pronto = PRONTO_IDLE;
      $display("txn seq run=%0d start_low_edge=%0d", r, d);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(L2 + 1, L2 + 4);
      start = 1'b1;
      for (int k = 0; k <= d; k++) begin
        @(posedge clk); #1;
        exp0 = exp_vec(0, k, d); exp2 = exp_vec(2, k, d);
        n_checks += 2;
        if (got0 !== exp0) $display("FAIL b2b dut0 k=%0d got=%h exp=%h", k, got0, exp0); else n_pass++;
        if (got2 !== exp2) $display("FAIL b2b dut2 k=%0d got=%h exp=%h", k, got2, exp2); else n_pass++;
        if (k + 1 == d) start = 1'b0;
      end
      // START low for exactly one sample, then the next request follows at once
      start = (r < 2);
      $display("txn b2b run=%0d start_low_edge=%0d", r, d);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int rr, d, e0, e2;
    for (int it = 0; it < 2; it++) begin
      rr = (it == 0) ? 4 : $urandom_range(10, 12);  // LOAD_B of dut0, then of dut2
      start = 1'b1;
      for (int k = 0; k < rr; k++) begin
        @(posedge clk); #1;
        exp0 = exp_vec(0, k, 1000); exp2 = exp_vec(2, k, 1000);
        n_checks += 2;
        if (got0 !== exp0) $display("FAIL pre_rst dut0 k=%0d got=%h exp=%h", k, got0, exp0); else n_pass++;
        if (got2 !== exp2) $display("FAIL pre_rst dut2 k=%0d got=%h exp=%h", k, got2, exp2); else n_pass++;
        if (k == rr - 1) rst_n = 1'b0;
      end
      @(posedge clk); #1;
      n_checks += 2;
      if (got0 !== 15'h0) $display("FAIL mid_rst dut0 got=%h exp=%h", got0, 15'h0); else n_pass++;
      if (got2 !== 15'h0) $display("FAIL mid_rst dut2 got=%h exp=%h", got2, 15'h0); else n_pass++;
      rst_n = 1'b1;
      d = $urandom_range(1, L2 + 3);
      e0 = maxi(d, L0); e2 = maxi(d, L2);
      for (int k = 0; k <= maxi(e0, e2) + 1; k++) begin
        @(posedge clk); #1;
        exp0 = exp_vec(0, k, e0); exp2 = exp_vec(2, k, e2);
        n_checks += 2;
        if (got0 !== exp0) $display("FAIL post_rst dut0 k=%0d got=%h exp=%h", k, got0, exp0); else n_pass++;
        if (got2 !== exp2) $display("FAIL post_rst dut2 k=%0d got=%h exp=%h", k, got2, exp2); else n_pass++;
        if (k + 1 == d) start = 1'b0;
      end
      $display("txn reset_mid reset_edge=%0d restart_low_edge=%0d", rr, d);
    end
  endtask

  task automatic test_datapath();
    int xs[6], ys[6], w;
    logic [15:0] want;
    xs[0] = 14;  ys[0] = 8;
    xs[1] = 255; ys[1] = 255;
    xs[2] = 0;   ys[2] = 77;
    for (int i = 3; i < 6; i++) begin xs[i] = $urandom_range(0, 255); ys[i] = $urandom_range(0, 255); end
    for (int i = 0; i < 6; i++) begin
      dp_xin = 8'(xs[i]); dp_yin = 8'(ys[i]);
      want = 16'(xs[i] * ys[i]);
      start = 1'b1;
      w = 0;
      while (w < 40 && !if0.DONE) begin @(posedge clk); #1; w++; end
      n_checks++;
      if (!if0.DONE) $display("FAIL dp_timeout x=%0d y=%0d done=%b required=1", xs[i], ys[i], if0.DONE);
      else if (dp_res !== want) $display("FAIL dp_result x=%0d y=%0d got=%0d exp=%0d", xs[i], ys[i], dp_res, want);
      else n_pass++;
      $display("txn dp x=%0d y=%0d res=%0d", xs[i], ys[i], dp_res);
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
    end
  endtask

`ifdef UC_MULT_PRONTO_CHECK_EN
  task automatic test_pronto();
    int k_err0, k_err2, k_done, j;
    logic erro_seen;
    pronto = 1'b0; start = 1'b1; k_err0 = -1; k_err2 = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (k_err0 < 0 && if0.ERRO) k_err0 = k;
      if (k_err2 < 0 && if2.ERRO) k_err2 = k;
    end
    n_checks += 3;
    if (k_err0 != 8 + 1 + TMO) $display("FAIL erro_cycle dut0 got=%0d exp=%0d", k_err0, 8 + 1 + TMO); else n_pass++;
    if (k_err2 != 24 + 1 + TMO) $display("FAIL erro_cycle dut2 got=%0d exp=%0d", k_err2, 24 + 1 + TMO); else n_pass++;
    if ({if0.BUSY, if0.DONE, if0.ERRO} !== 3'b001)
      $display("FAIL err_state dut0 got=%b exp=001", {if0.BUSY, if0.DONE, if0.ERRO}); else n_pass++;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (got0 !== 15'h0) $display("FAIL err_exit dut0 got=%h exp=%h", got0, 15'h0); else n_pass++;
    $display("txn pronto_timeout erro_cycle=%0d", k_err0);
    for (int it = 0; it < 2; it++) begin
      j = (it == 0) ? $urandom_range(1, TMO) : TMO;  // TMO: PRONTO on the expiry edge
      pronto = 1'b0; start = 1'b1; k_done = -1; erro_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (k_done < 0 && if0.DONE) k_done = k;
        if (if0.ERRO) erro_seen = 1'b1;
        if (k == 8 + j - 1) pronto = 1'b1;
      end
      n_checks += 2;
      if (k_done != 8 + j + 1) $display("FAIL pronto_done j=%0d got=%0d exp=%0d", j, k_done, 8 + j + 1); else n_pass++;
      if (erro_seen !== 1'b0) $display("FAIL pronto_erro j=%0d got=%b exp=0", j, erro_seen); else n_pass++;
      $display("txn pronto_at_sample=%0d done_cycle=%0d", j, k_done);
      start = 1'b0; pronto = PRONTO_IDLE;
      repeat (40) @(posedge clk);
      #1;
    end
  endtask
`else
  task automatic test_pronto();
    test_sequence(2, 1'b1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; pronto = PRONTO_IDLE;
    dp_xin = '0; dp_yin = '0;
    test_reset();
    test_sequence(4, 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_datapath();
    test_pronto();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
